// File: rtl/seq_datapath_pkg.sv
// Shared types for the sequenced datapath: opcodes, shifter controls, sequencer states.
package seq_datapath_pkg;

  typedef enum logic [2:0] {
    OP_MOVI = 3'd0,
    OP_MOV  = 3'd1,
    OP_ADD  = 3'd2,
    OP_CMP  = 3'd3,
    OP_AND  = 3'd4,
    OP_MVN  = 3'd5,
    OP_LDM  = 3'd6,
    OP_ADDI = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    SH_PASS = 2'd0,
    SH_LSL  = 2'd1,
    SH_LSR  = 2'd2,
    SH_ASR  = 2'd3
  } shift_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_e;

  // Ops that need no register operands jump straight from accept to EXEC.
  function automatic logic op_no_reads(input op_e op);
    return (op == OP_MOVI) || (op == OP_LDM);
  endfunction

  // Only the arithmetic ops touch the status flags.
  function automatic logic op_sets_flags(input op_e op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// General register file: NREG x W, two combinational read ports, one synchronous write port.
module seq_regfile
  import seq_datapath_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(NREG)-1:0]  raddr_a,
  input  logic [$clog2(NREG)-1:0]  raddr_b,
  output logic [W-1:0]             rdata_a,
  output logic [W-1:0]             rdata_b
);

  logic [W-1:0] regs [NREG];

  // Write port; the whole array clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/seq_datapath.sv
// Sequenced datapath: one valid/ready request runs read-A, read-B, execute and write-back.
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int IMMW = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [$clog2(NREG)-1:0]  req_rd,
  input  logic [$clog2(NREG)-1:0]  req_rn,
  input  logic [$clog2(NREG)-1:0]  req_rm,
  input  logic [1:0]               req_shift,
  input  logic [IMMW-1:0]          req_imm,
  input  logic [W-1:0]             mdata,
  output logic                     rsp_valid,
  output logic [W-1:0]             rsp_data,
  output logic                     z_out,
  output logic                     n_out,
  output logic                     v_out,
  output logic                     busy
);

  localparam int RW = $clog2(NREG);

  // Shifter applied to the B operand; shifts are by one place only.
  function automatic logic signed [W-1:0] shift_b(input logic signed [W-1:0] x, input shift_e s);
    logic signed [W-1:0] r;
    case (s)
      SH_LSL:  r = {x[W-2:0], 1'b0};
      SH_LSR:  r = {1'b0, x[W-1:1]};
      SH_ASR:  r = {x[W-1], x[W-1:1]};
      default: r = x;
    endcase
    return r;
  endfunction

  // Immediate sign extension to the datapath width.
  function automatic logic signed [W-1:0] sext_imm(input logic [IMMW-1:0] i);
    logic signed [IMMW-1:0] s;
    s = i;
    return W'(s);
  endfunction

  // Signed overflow: operands agree in sign and the sum does not.
  function automatic logic add_ovf(input logic signed [W-1:0] x, y, r);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Signed overflow of x - y: operands differ in sign and the result follows y.
  function automatic logic sub_ovf(input logic signed [W-1:0] x, y, r);
    return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  state_e              state;
  op_e                 op_q;
  logic [RW-1:0]       rd_q, rn_q, rm_q;
  shift_e              shift_q;
  logic [IMMW-1:0]     imm_q;

  logic signed [W-1:0] a_p0, b_p1, c_p2;
  logic [W-1:0]        rf_a, rf_b;
  logic                rf_we;

  logic signed [W-1:0] b_sh, imm_x, alu_res;
  logic                v_nxt;

  seq_regfile #(.W(W), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (c_p2),
    .raddr_a (rn_q),
    .raddr_b (rm_q),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  // Write-back commits on the edge ending WB; CMP only produces flags.
  assign rf_we    = (state == WB) && (op_q != OP_CMP);
  assign rsp_data = c_p2;

  // ALU and result mux for the EXEC stage.
  always_comb begin
    b_sh    = shift_b(b_p1, shift_q);
    imm_x   = sext_imm(imm_q);
    alu_res = '0;
    v_nxt   = 1'b0;
    case (op_q)
      OP_MOVI: alu_res = imm_x;
      OP_MOV:  alu_res = b_sh;
      OP_ADD: begin
        alu_res = a_p0 + b_sh;
        v_nxt   = add_ovf(a_p0, b_sh, alu_res);
      end
      OP_CMP: begin
        alu_res = a_p0 - b_sh;
        v_nxt   = sub_ovf(a_p0, b_sh, alu_res);
      end
      OP_AND:  alu_res = a_p0 & b_sh;
      OP_MVN:  alu_res = ~b_sh;
      OP_LDM:  alu_res = mdata;
      OP_ADDI: begin
        alu_res = a_p0 + imm_x;
        v_nxt   = add_ovf(a_p0, imm_x, alu_res);
      end
      default: alu_res = '0;
    endcase
  end

  // Micro-sequencer with the A/B/C registers, flags and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_q      <= OP_MOVI;
      rd_q      <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      shift_q   <= SH_PASS;
      imm_q     <= '0;
      a_p0      <= '0;
      b_p1      <= '0;
      c_p2      <= '0;
      z_out     <= 1'b0;
      n_out     <= 1'b0;
      v_out     <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE, WB: begin
          // A request taken in WB behaves exactly like one taken in IDLE.
          if (req_valid) begin
            op_q      <= op_e'(req_op);
            rd_q      <= req_rd;
            rn_q      <= req_rn;
            rm_q      <= req_rm;
            shift_q   <= shift_e'(req_shift);
            imm_q     <= req_imm;
            state     <= op_no_reads(op_e'(req_op)) ? EXEC : RDA;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        RDA: begin
          // Stage A: first source operand.
          a_p0  <= rf_a;
          state <= RDB;
        end
        RDB: begin
          // Stage B: second source operand, shifted later in EXEC.
          b_p1  <= rf_b;
          state <= EXEC;
        end
        EXEC: begin
          // Stage C: result and flags, presented during WB.
          c_p2 <= alu_res;
          if (op_sets_flags(op_q)) begin
            z_out <= (alu_res == '0);
            n_out <= alu_res[W-1];
            v_out <= v_nxt;
          end
          state     <= WB;
          rsp_valid <= 1'b1;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_datapath.sv
// Directed bench for seq_datapath with hand-computed expectations (W=16, NREG=8, IMMW=8).
module tb_seq_datapath;

  localparam logic [2:0] O_MOVI = 3'd0, O_MOV = 3'd1, O_ADD = 3'd2, O_CMP = 3'd3,
                         O_AND  = 3'd4, O_MVN = 3'd5, O_LDM = 3'd6, O_ADDI = 3'd7;

  logic        clk, reset_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op, req_rd, req_rn, req_rm;
  logic [1:0]  req_shift;
  logic [7:0]  req_imm;
  logic [15:0] mdata, rsp_data;
  logic        rsp_valid, z_out, n_out, v_out, busy;

  int n_err = 0;
  int n_chk = 0;

  seq_datapath #(.W(16), .NREG(8), .IMMW(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rd    (req_rd),
    .req_rn    (req_rn),
    .req_rm    (req_rm),
    .req_shift (req_shift),
    .req_imm   (req_imm),
    .mdata     (mdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .z_out     (z_out),
    .n_out     (n_out),
    .v_out     (v_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] op, rd, rn, rm, input logic [1:0] sh, input logic [7:0] imm);
    req_op = op; req_rd = rd; req_rn = rn; req_rm = rm; req_shift = sh; req_imm = imm;
  endtask

  // Called at a falling edge; issues one request and waits for its response.
  task automatic run_op(input string tag, input logic [2:0] op, rd, rn, rm, input logic [1:0] sh,
                        input logic [7:0] imm, input logic [15:0] exp_data, input int exp_lat);
    int n, nbusy, guard;
    bit seen;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    set_req(op, rd, rn, rm, sh, imm);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0; nbusy = 0; seen = 0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
      if (rsp_valid) seen = 1;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_busy"}, nbusy, exp_lat);
  endtask

  int          rcyc[$];
  logic [15:0] rdat[$];
  int          exp_c[3] = '{2, 4, 8};
  logic [15:0] exp_d[3] = '{16'h0012, 16'hBEEF, 16'hDF77};
  int          stage;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; mdata = '0;
    set_req(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'd0);
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp", rsp_valid, 0);
    check("rst_flags", {z_out, n_out, v_out}, 3'b000);
    check("rst_c", rsp_data, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of an ADD
    run_op("movi9", O_MOVI, 3'd0, 3'd0, 3'd0, 2'd0, 8'h09, 16'h0009, 2);
    set_req(O_ADD, 3'd2, 3'd0, 3'd0, 2'd0, 8'd0);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midadd_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_rsp", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", req_ready, 1);
    check("midrst_flags", {z_out, n_out, v_out}, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("postrst_rsp", rsp_valid, 0);
    run_op("rd_clear", O_MOV, 3'd3, 3'd0, 3'd2, 2'd0, 8'd0, 16'h0000, 4);
    run_op("r0_clear", O_MOV, 3'd3, 3'd0, 3'd0, 2'd0, 8'd0, 16'h0000, 4);

    // Immediates and shifted add
    run_op("movi5", O_MOVI, 3'd0, 3'd0, 3'd0, 2'd0, 8'h05, 16'h0005, 2);
    run_op("movim3", O_MOVI, 3'd1, 3'd0, 3'd0, 2'd0, 8'hFD, 16'hFFFD, 2);
    run_op("add_lsl", O_ADD, 3'd2, 3'd0, 3'd1, 2'd1, 8'd0, 16'hFFFF, 4);
    check("add_flags", {z_out, n_out, v_out}, 3'b010);

    // Build 0x7F00 then overflow
    run_op("movi7f", O_MOVI, 3'd3, 3'd0, 3'd0, 2'd0, 8'h7F, 16'h007F, 2);
    for (int i = 1; i <= 8; i++)
      run_op("lsl_step", O_MOV, 3'd3, 3'd0, 3'd3, 2'd1, 8'd0, 16'(16'h007F << i), 4);
    check("mov_holds_flags", {z_out, n_out, v_out}, 3'b010);
    run_op("add_ovf", O_ADD, 3'd4, 3'd3, 3'd3, 2'd0, 8'd0, 16'hFE00, 4);
    check("ovf_flags", {z_out, n_out, v_out}, 3'b011);

    // Compare, then ops that hold flags
    run_op("cmp", O_CMP, 3'd7, 3'd0, 3'd0, 2'd0, 8'd0, 16'h0000, 4);
    check("cmp_flags", {z_out, n_out, v_out}, 3'b100);
    run_op("r0_kept", O_MOV, 3'd6, 3'd0, 3'd0, 2'd0, 8'd0, 16'h0005, 4);
    run_op("and", O_AND, 3'd5, 3'd0, 3'd1, 2'd0, 8'd0, 16'h0005, 4);
    check("and_flags", {z_out, n_out, v_out}, 3'b100);
    run_op("mvn_lsr", O_MVN, 3'd6, 3'd0, 3'd0, 2'd2, 8'd0, 16'hFFFD, 4);
    run_op("addi", O_ADDI, 3'd6, 3'd0, 3'd0, 2'd0, 8'hFF, 16'h0004, 4);
    check("addi_flags", {z_out, n_out, v_out}, 3'b000);
    run_op("add_dbl", O_ADD, 3'd2, 3'd2, 3'd2, 2'd0, 8'd0, 16'hFFFE, 4);

    // Back-to-back with req_valid held high
    mdata = 16'hBEEF;
    set_req(O_MOVI, 3'd5, 3'd0, 3'd0, 2'd0, 8'h12);
    req_valid = 1'b1;
    stage = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rcyc.push_back(c);
        rdat.push_back(rsp_data);
        stage++;
        if (stage == 1)      set_req(O_LDM, 3'd6, 3'd0, 3'd0, 2'd0, 8'd0);
        else if (stage == 2) set_req(O_MOV, 3'd7, 3'd0, 3'd6, 2'd3, 8'd0);
        else                 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_count", rcyc.size(), 3);
    for (int i = 0; i < rcyc.size() && i < 3; i++) begin
      check("b2b_cycle", rcyc[i], exp_c[i]);
      check("b2b_data", rdat[i], exp_d[i]);
    end
    run_op("r7_final", O_MOV, 3'd1, 3'd0, 3'd7, 2'd0, 8'd0, 16'hDF77, 4);
    run_op("r6_ldm", O_MOV, 3'd1, 3'd0, 3'd6, 2'd0, 8'd0, 16'hBEEF, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
